// File: rtl/mm_trg_multi.sv
// mm_trg_multi: multi-lane threshold trigger with hysteresis, retrigger extension and self-computed baseline.
// Define BASELINE_TRACK_EN to keep refreshing the baseline over quiet windows while armed.
module mm_trg_multi #(
    parameter int SAMPLE_NUM           = 8,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int THRESHOLD            = 410,
    parameter int HYSTERESIS           = 16,
    parameter bit POLARITY             = 1'b0,
    parameter int BASELINE_LOG2        = 4,
    parameter int POST_ACQUI_LEN       = 38,
    parameter int TIME_STAMP_WIDTH     = 16,
    localparam int LANE_W = (SAMPLE_NUM > 1) ? $clog2(SAMPLE_NUM) : 1
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESET,
    input  logic                            EN,
    input  logic [SAMPLE_NUM*16-1:0]        S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    input  logic [TIME_STAMP_WIDTH-1:0]     CURRENT_TIME,
    output logic [ADC_RESOLUTION_WIDTH-1:0] O_BASELINE,
    output logic                            O_BL_VALID,
    output logic                            O_START_TRG,
    output logic                            O_FINALIZE_TRG,
    output logic [TIME_STAMP_WIDTH-1:0]     O_TIME_STAMP,
    output logic [LANE_W-1:0]               O_HIT_LANE,
    output logic                            O_TRG_BUSY
);

    localparam int AW    = ADC_RESOLUTION_WIDTH;
    localparam int ACC_W = AW + BASELINE_LOG2;
    localparam int BLC_W = BASELINE_LOG2 + 1;
    localparam int PC_W  = $clog2(POST_ACQUI_LEN + 1);

    localparam logic [BLC_W-1:0]  BL_LAST   = BLC_W'((1 << BASELINE_LOG2) - 1);
    localparam logic [PC_W-1:0]   POST_LAST = PC_W'(POST_ACQUI_LEN - 1);
    localparam logic signed [AW:0] TRG_LVL  = (AW+1)'(THRESHOLD);
    localparam logic signed [AW:0] REL_LVL  = (AW+1)'(THRESHOLD - HYSTERESIS);

    typedef enum logic [1:0] {BL_CALC, ARMED, ACTIVE, POST} state_t;

    state_t                  state, state_next;
    logic [SAMPLE_NUM-1:0]   hit;
    logic                    any_hit;
    logic                    rel_all;
    logic [LANE_W-1:0]       hit_lane;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;
    logic [BLC_W-1:0]        bl_cnt;
    logic                    win_end;
    logic [PC_W-1:0]         post_cnt;
    logic                    start_evt, fin_evt, post_clr, post_inc;
`ifdef BASELINE_TRACK_EN
    logic                    win_hit;
`endif

    // Upper lane bits above the ADC resolution carry no information.
    logic unused_tdata;
    assign unused_tdata = ^S_AXIS_TDATA;

    always_comb begin : lane_eval
        logic signed [AW:0] smp;
        logic signed [AW:0] bse;
        logic signed [AW:0] d;
        // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
        hit     = '0;
        rel_all = 1'b1;
        smp     = '0;
        bse     = '0;
        d       = '0;
        for (int i = 0; i < SAMPLE_NUM; i++) begin
            smp    = $signed({1'b0, S_AXIS_TDATA[16*i +: AW]});
            bse    = $signed({1'b0, O_BASELINE});
            d      = POLARITY ? (smp - bse) : (bse - smp);
            hit[i] = d > TRG_LVL;
            if (d >= REL_LVL) rel_all = 1'b0;
        end
    end

    always_comb begin
        hit_lane = '0;
        for (int i = SAMPLE_NUM - 1; i >= 0; i--) begin
            if (hit[i]) hit_lane = LANE_W'(i);
        end
    end

    assign any_hit    = |hit;
    assign acc_sum    = acc + ACC_W'(S_AXIS_TDATA[AW-1:0]);
    assign win_end    = (bl_cnt == BL_LAST);
    assign O_TRG_BUSY = (state == ACTIVE) || (state == POST);

    always_comb begin
        state_next = state;
        start_evt  = 1'b0;
        fin_evt    = 1'b0;
        post_clr   = 1'b0;
        post_inc   = 1'b0;
        if (S_AXIS_TVALID) begin
            case (state)
                BL_CALC: if (win_end) state_next = ARMED;
                ARMED: begin
                    if (any_hit && EN) begin
                        state_next = ACTIVE;
                        start_evt  = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!any_hit && rel_all) begin
                        state_next = POST;
                        post_clr   = 1'b1;
                    end
                end
                POST: begin
                    // A fresh hit extends the current event instead of opening a new one.
                    if (any_hit) begin
                        state_next = ACTIVE;
                        post_clr   = 1'b1;
                    end else if (post_cnt == POST_LAST) begin
                        state_next = ARMED;
                        fin_evt    = 1'b1;
                        post_clr   = 1'b1;
                    end else begin
                        post_inc = 1'b1;
                    end
                end
                default: state_next = BL_CALC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) state <= BL_CALC;
        else             state <= state_next;
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            acc            <= '0;
            bl_cnt         <= '0;
            post_cnt       <= '0;
            O_BASELINE     <= '0;
            O_BL_VALID     <= 1'b0;
            O_START_TRG    <= 1'b0;
            O_FINALIZE_TRG <= 1'b0;
            O_TIME_STAMP   <= '0;
            O_HIT_LANE     <= '0;
`ifdef BASELINE_TRACK_EN
            win_hit        <= 1'b0;
`endif
        end else begin
            O_START_TRG    <= start_evt;
            O_FINALIZE_TRG <= fin_evt;
            if (start_evt) begin
                O_TIME_STAMP <= CURRENT_TIME;
                O_HIT_LANE   <= hit_lane;
            end
            if (post_clr)      post_cnt <= '0;
            else if (post_inc) post_cnt <= post_cnt + 1'b1;

            if (S_AXIS_TVALID) begin
                if (state == BL_CALC) begin
                    if (win_end) begin
                        O_BASELINE <= acc_sum[ACC_W-1:BASELINE_LOG2];
                        O_BL_VALID <= 1'b1;
                        acc        <= '0;
                        bl_cnt     <= '0;
                    end else begin
                        acc    <= acc_sum;
                        bl_cnt <= bl_cnt + 1'b1;
                    end
                end
`ifdef BASELINE_TRACK_EN
                else if (state == ARMED && !start_evt) begin
                    if (win_end) begin
                        if (!(win_hit || any_hit)) O_BASELINE <= acc_sum[ACC_W-1:BASELINE_LOG2];
                        acc     <= '0;
                        bl_cnt  <= '0;
                        win_hit <= 1'b0;
                    end else begin
                        acc     <= acc_sum;
                        bl_cnt  <= bl_cnt + 1'b1;
                        win_hit <= win_hit | any_hit;
                    end
                end
`endif
                else begin
                    acc    <= '0;
                    bl_cnt <= '0;
`ifdef BASELINE_TRACK_EN
                    win_hit <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mm_trg_multi.sv
// Directed self-checking bench for mm_trg_multi: a negative-polarity DUT plus a positive-polarity twin.
module tb_mm_trg_multi;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic [15:0]  cur_time;

    logic [11:0]  baseline, p_baseline;
    logic         bl_valid, p_bl_valid;
    logic         start_trg, p_start_trg;
    logic         fin_trg, p_fin_trg;
    logic [15:0]  time_stamp, p_time_stamp;
    logic [2:0]   hit_lane, p_hit_lane;
    logic         busy, p_busy;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int n_fin    = 0;

    always #5 clk = ~clk;

    mm_trg_multi u_neg (
        .AXIS_ACLK      (clk),
        .AXIS_ARESET    (rst),
        .EN             (en),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TVALID  (s_tvalid),
        .CURRENT_TIME   (cur_time),
        .O_BASELINE     (baseline),
        .O_BL_VALID     (bl_valid),
        .O_START_TRG    (start_trg),
        .O_FINALIZE_TRG (fin_trg),
        .O_TIME_STAMP   (time_stamp),
        .O_HIT_LANE     (hit_lane),
        .O_TRG_BUSY     (busy)
    );

    mm_trg_multi #(.POLARITY(1'b1)) u_pos (
        .AXIS_ACLK      (clk),
        .AXIS_ARESET    (rst),
        .EN             (en),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TVALID  (s_tvalid),
        .CURRENT_TIME   (cur_time),
        .O_BASELINE     (p_baseline),
        .O_BL_VALID     (p_bl_valid),
        .O_START_TRG    (p_start_trg),
        .O_FINALIZE_TRG (p_fin_trg),
        .O_TIME_STAMP   (p_time_stamp),
        .O_HIT_LANE     (p_hit_lane),
        .O_TRG_BUSY     (p_busy)
    );

    always @(negedge clk) begin
        if (start_trg) n_start <= n_start + 1;
        if (fin_trg)   n_fin   <= n_fin + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] lanes(input int v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(v);
        return r;
    endfunction

    function automatic logic [127:0] set_lane(input logic [127:0] d, input int idx, input int v);
        logic [127:0] r;
        r = d;
        r[16*idx +: 16] = 16'(v);
        return r;
    endfunction

    task automatic beat(input logic [127:0] d, input logic v);
        s_tdata  = d;
        s_tvalid = v;
        @(posedge clk);
        #1;
    endtask

    // Feed quiet valid beats until finalize shows; report how many beats that took.
    task automatic run_post(input string tag, input int exp_beats);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            beat(lanes(2048), 1'b1);
            n++;
            if (fin_trg) seen = 1'b1;
        end
        check(tag, 32'(n), 32'(exp_beats));
        beat(lanes(2048), 1'b1);
        check({tag, "_one_cycle"}, 32'(fin_trg), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  n;
        int  cyc;
        bit  seen;

        rst      = 1'b1;
        en       = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        cur_time = '0;
        beat(lanes(0), 1'b0);
        beat(lanes(0), 1'b0);
        check("rst_flags", 32'({bl_valid, start_trg, fin_trg, busy}), 32'd0);
        check("rst_values", 32'({baseline, hit_lane, time_stamp}), 32'd0);
        rst = 1'b0;

        // Baseline: 15 valid beats, idle gaps must not count, then the 16th.
        for (int k = 0; k < 15; k++) beat(lanes(2048), 1'b1);
        for (int k = 0; k < 3; k++) beat(lanes(2048), 1'b0);
        check("bl_not_yet", 32'(bl_valid), 32'd0);
        beat(lanes(2048), 1'b1);
        check("bl_valid", 32'(bl_valid), 32'd1);
        check("bl_value", 32'(baseline), 32'd2048);
        check("bl_no_trg", 32'(n_start), 32'd0);

        // Single-lane event with timestamp.
        en       = 1'b1;
        cur_time = 16'h0123;
        beat(set_lane(lanes(2048), 5, 1600), 1'b1);
        check("start_pulse", 32'(start_trg), 32'd1);
        check("start_lane", 32'(hit_lane), 32'd5);
        check("start_ts", 32'(time_stamp), 32'h0123);
        check("start_busy", 32'(busy), 32'd1);
        cur_time = 16'h0999;
        beat(lanes(2048), 1'b0);
        check("start_one_cycle", 32'(start_trg), 32'd0);
        beat(lanes(2048), 1'b1);
        run_post("post_len", 38);

        // Hysteresis: 1650 holds ACTIVE, 1660 releases.
        cur_time = 16'h0200;
        beat(set_lane(lanes(2048), 0, 1600), 1'b1);
        check("hys_start_lane", 32'(hit_lane), 32'd0);
        for (int k = 0; k < 5; k++) beat(lanes(1650), 1'b1);
        check("hys_hold_busy", 32'(busy), 32'd1);
        beat(lanes(1660), 1'b1);
        check("hys_release_busy", 32'(busy), 32'd1);
        run_post("hys_post_len", 38);

        // Two lanes at once, then a retrigger inside the post window.
        cur_time = 16'h0300;
        beat(set_lane(set_lane(lanes(2048), 2, 1500), 6, 1500), 1'b1);
        check("multi_lane", 32'(hit_lane), 32'd2);
        beat(lanes(2048), 1'b1);
        for (int k = 0; k < 19; k++) beat(lanes(2048), 1'b1);
        check("ext_no_early_fin", 32'(n_fin), 32'd2);
        cur_time = 16'h0333;
        beat(set_lane(lanes(2048), 7, 1500), 1'b1);
        check("ext_no_start", 32'(start_trg), 32'd0);
        check("ext_hold_lane_ts", 32'({hit_lane, time_stamp}), 32'({3'd2, 16'h0300}));
        beat(lanes(2048), 1'b1);
        run_post("ext_post_len", 38);
        check("ext_start_count", 32'(n_start), 32'd3);
        check("ext_fin_count", 32'(n_fin), 32'd3);

        // TVALID toggling during POST; idle beats carry hit data that must be ignored.
        cur_time = 16'h0400;
        beat(set_lane(lanes(2048), 1, 1600), 1'b1);
        beat(lanes(2048), 1'b1);
        n    = 0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            beat(lanes(2048), 1'b1);
            n++;
            cyc++;
            if (fin_trg) seen = 1'b1;
            beat(set_lane(lanes(2048), 0, 1000), 1'b0);
            cyc++;
        end
        check("toggle_valid_beats", 32'(n), 32'd38);
        check("toggle_cycles", 32'(cyc), 32'd76);
        check("toggle_fin_drops", 32'(fin_trg), 32'd0);

        // EN falling mid-event still completes it; EN=0 blocks new starts.
        en       = 1'b1;
        cur_time = 16'h0500;
        beat(set_lane(lanes(2048), 4, 1600), 1'b1);
        check("enfall_lane", 32'(hit_lane), 32'd4);
        en = 1'b0;
        beat(lanes(2048), 1'b1);
        run_post("enfall_post_len", 38);
        beat(set_lane(lanes(2048), 0, 1000), 1'b1);
        beat(set_lane(lanes(2048), 0, 1000), 1'b1);
        check("en_off_no_start", 32'({start_trg, busy}), 32'd0);
        check("en_off_start_count", 32'(n_start), 32'd5);
        check("en_off_fin_count", 32'(n_fin), 32'd5);

        // Reset in the middle of an event.
        en       = 1'b1;
        cur_time = 16'h0600;
        beat(set_lane(lanes(2048), 3, 1600), 1'b1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        beat(lanes(2048), 1'b1);
        check("midrst_flags", 32'({bl_valid, start_trg, fin_trg, busy}), 32'd0);
        check("midrst_values", 32'({baseline, hit_lane, time_stamp}), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) beat(lanes(2000), 1'b1);
        check("rebl_value", 32'(baseline), 32'd2000);
        check("rebl_valid", 32'(bl_valid), 32'd1);
        check("rebl_pos_value", 32'(p_baseline), 32'd2000);
        check("midrst_no_fin", 32'(n_fin), 32'd5);

        // Positive polarity twin fires on an upward excursion; negative one does not.
        cur_time = 16'h0777;
        beat(set_lane(lanes(2000), 3, 2500), 1'b1);
        check("pos_start", 32'(p_start_trg), 32'd1);
        check("pos_lane_ts", 32'({p_hit_lane, p_time_stamp}), 32'({3'd3, 16'h0777}));
        check("neg_ignores_up", 32'({start_trg, busy}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_trg_multi.md
Name: mm_trg_multi

Overview:
- Parametrised successor to the single-lane minimum trigger: threshold trigger over all SAMPLE_NUM lanes of a parallel RF Data Converter beat.
- Adds selectable polarity, hysteresis release, post-window retrigger extension, arm/disarm and hit-lane reporting.
- Computes its own baseline from lane 0, then issues start/finalize pulses plus timestamp to the downstream m_axis_IF packetiser.

Parameters:
SAMPLE_NUM, 8, samples per beat; S_AXIS_TDATA width = SAMPLE_NUM*16
ADC_RESOLUTION_WIDTH, 12, unsigned sample bits, right-aligned in each 16-bit lane; upper lane bits ignored
THRESHOLD, 410, trigger level in ADC counts relative to baseline
HYSTERESIS, 16, release margin; constraint 0 <= HYSTERESIS <= THRESHOLD
POLARITY, 0, 0 = negative-going (minimum) pulses, 1 = positive-going
BASELINE_LOG2, 4, baseline averages 2^BASELINE_LOG2 valid beats
POST_ACQUI_LEN, 38, valid beats after release before finalize; constraint >= 1
TIME_STAMP_WIDTH, 16, timestamp width

Ports:
AXIS_ACLK  in  1  clock
AXIS_ARESET  in  1  reset
EN  in  1  arm enable
S_AXIS_TDATA  in  SAMPLE_NUM*16  sample beat, lane i = bits [16i+15:16i]
S_AXIS_TVALID  in  1  beat qualifier
CURRENT_TIME  in  TIME_STAMP_WIDTH  from time_counter
O_BASELINE  out  ADC_RESOLUTION_WIDTH  computed baseline
O_BL_VALID  out  1  baseline ready, level
O_START_TRG  out  1  one-cycle pulse
O_FINALIZE_TRG  out  1  one-cycle pulse
O_TIME_STAMP  out  TIME_STAMP_WIDTH  CURRENT_TIME latched on hit beat
O_HIT_LANE  out  clog2(SAMPLE_NUM)  lowest hit lane index
O_TRG_BUSY  out  1  high in ACTIVE and POST

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- AXIS_ARESET high: state BL_CALC, accumulator/counters 0; every output 0.
- Only cycles with S_AXIS_TVALID=1 advance state or counters; TVALID=0 holds everything; pulse outputs return to 0.
- Per lane, signed (ADC_RESOLUTION_WIDTH+1)-bit d = POLARITY ? sample-baseline : baseline-sample.
- hit_i = d > THRESHOLD (strict). release = every lane d < THRESHOLD-HYSTERESIS.
- BL_CALC: accumulate lane 0 into (ADC_RESOLUTION_WIDTH+BASELINE_LOG2)-bit register.
  - After 2^BASELINE_LOG2 valid beats: O_BASELINE = acc >> BASELINE_LOG2 (truncate); O_BL_VALID=1 on the next cycle; -> ARMED.
  - Runs regardless of EN.
- ARMED: on a valid beat with any hit and EN=1, the next cycle shows:
  - O_START_TRG=1 for one cycle (latency 1);
  - O_TIME_STAMP = CURRENT_TIME from the hit beat;
  - O_HIT_LANE = lowest index with hit;
  - state -> ACTIVE. EN=0: hits ignored.
- ACTIVE: valid beat with release -> POST, post counter = 0. Otherwise stay.
- POST, per valid beat:
  - any hit -> ACTIVE, counter cleared, no new O_START_TRG (extends event);
  - else counter++; when counter reaches POST_ACQUI_LEN, O_FINALIZE_TRG=1 next cycle, -> ARMED.
- Hit and release on the same beat cannot occur (HYSTERESIS>=0); hit takes priority.
- EN falling during ACTIVE/POST: event completes normally, finalize still issued; no new start until EN=1.
- Every START is followed by exactly one FINALIZE unless reset intervenes.
- O_TIME_STAMP and O_HIT_LANE hold until the next start.
- Reset mid-event: immediate return to BL_CALC, no finalize; O_BL_VALID drops.

Optional Feature:
- Macro BASELINE_TRACK_EN.
- Defined: in ARMED, accumulation continues over successive 2^BASELINE_LOG2-beat windows. O_BASELINE updates at window end only if no hit occurred in that window. Accumulator restarts on leaving ARMED and on each window end.
- Undefined: baseline frozen after the first calculation until reset.

Test Plan:
1. Reset, 16 valid beats all lanes 2048 -> O_BL_VALID rises after beat 16, O_BASELINE=2048, no triggers.
2. Armed, lane 5=1600 (d=448), CURRENT_TIME=0x0123 -> O_START_TRG one cycle later, O_HIT_LANE=5, O_TIME_STAMP=0x0123. Then all 2048 -> O_FINALIZE_TRG exactly 38 valid beats after the release beat.
3. Hysteresis: during ACTIVE, lanes at 1650 (d=398, not <394) -> stays ACTIVE, no finalize. 1660 (d=388) -> enters POST.
4. Lanes 2 and 6 both at 1500 on the same beat -> O_HIT_LANE=2. Hit on beat 20 of POST -> single event, finalize 38 beats after the second release, only one START.
5. TVALID toggled 1/0 every cycle during POST -> finalize after 38 valid beats (~76 cycles). EN=0 with lane 0=1000 -> no START.
6. Reset asserted mid-ACTIVE -> all outputs 0 next cycle, no FINALIZE, baseline recalculated. POLARITY=1 with lane 3=2500 -> START, O_HIT_LANE=3.
